// File: rtl/mem_seq_arbiter.sv
// Sequencer arbitrating a CPU vector/scalar port and a DMA word port onto one sync RAM.
// Define ARB_RR_EN for round-robin tie-break; otherwise the CPU always wins ties.
module mem_seq_arbiter #(
  parameter int ADDR_W = 13,
  parameter int LANES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic                   cpu_vs,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [LANES-1:0][31:0] cpu_wdata,
  output logic [LANES-1:0][31:0] cpu_rdata,
  output logic                   cpu_done,
  output logic                   cpu_stall,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [ADDR_W-1:0]      dma_addr,
  input  logic [31:0]            dma_wdata,
  output logic [31:0]            dma_rdata,
  output logic                   dma_done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CPU_XFER,
    DMA_XFER,
    DRAIN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dma_q, dma_d;
  logic                   we_q, we_d;
  logic                   vs_q, vs_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LANES-1:0][31:0] wdata_q, wdata_d;
  logic                   cap_v_q, cap_v_d;
  logic [CW-1:0]          cap_lane_q, cap_lane_d;
  logic [LANES-1:0][31:0] crd_q, crd_d;
  logic [31:0]            drd_q, drd_d;

  logic          grant_cpu;
  logic          beat;
  logic          last_beat;
  logic [CW-1:0] lane;

`ifdef ARB_RR_EN
  // last_q = 1 means the DMA was granted most recently
  logic last_q, last_d;
  assign grant_cpu = cpu_req & (~dma_req | last_q);
`else
  assign grant_cpu = cpu_req;
`endif

  assign beat = (state_q == CPU_XFER) ||
                (state_q == DMA_XFER);
  assign lane = CW'(LANES - 1) - cnt_q;
  assign last_beat = ~vs_q |
                     (cnt_q == CW'(LANES - 1));

  assign mem_we    = beat & we_q;
  assign mem_addr  = beat ?
                     (addr_q + ADDR_W'(cnt_q)) : '0;
  assign mem_wdata = (beat & we_q) ?
                     wdata_q[lane] : '0;

  assign cpu_done  = (state_q == DONE) & ~dma_q;
  assign dma_done  = (state_q == DONE) & dma_q;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = crd_q;
  assign dma_rdata = drd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dma_d   = dma_q;
    we_d    = we_q;
    vs_d    = vs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_cpu) begin
          state_d = CPU_XFER;
          dma_d   = 1'b0;
          we_d    = cpu_we;
          vs_d    = cpu_vs;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
`ifdef ARB_RR_EN
          last_d  = 1'b0;
`endif
        end else if (dma_req) begin
          state_d = DMA_XFER;
          dma_d   = 1'b1;
          we_d    = dma_we;
          vs_d    = 1'b0;
          addr_d  = dma_addr;
          wdata_d = '0;
          wdata_d[LANES-1] = dma_wdata;
`ifdef ARB_RR_EN
          last_d  = 1'b1;
`endif
        end
      end
      CPU_XFER, DMA_XFER: begin
        if (last_beat) begin
          cnt_d   = '0;
          state_d = we_q ? DONE : DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load data for a beat lands one cycle later; capture it then
  always_comb begin
    cap_v_d    = beat & ~we_q;
    cap_lane_d = lane;
    crd_d      = crd_q;
    drd_d      = drd_q;
    if (cap_v_q) begin
      if (dma_q) begin
        drd_d = mem_rdata;
      end else if (vs_q) begin
        crd_d[cap_lane_q] = mem_rdata;
      end else begin
        crd_d = '0;
        crd_d[LANES-1] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dma_q      <= 1'b0;
      we_q       <= 1'b0;
      vs_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_v_q    <= 1'b0;
      cap_lane_q <= '0;
      crd_q      <= '0;
      drd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dma_q      <= dma_d;
      we_q       <= we_d;
      vs_q       <= vs_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cap_v_q    <= cap_v_d;
      cap_lane_q <= cap_lane_d;
      crd_q      <= crd_d;
      drd_q      <= drd_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_seq_arbiter.sv
// Randomized and directed bench for mem_seq_arbiter against a transaction-level model.
// Honors ARB_RR_EN for the expected tie-break order.
module tb_mem_seq_arbiter;

  localparam int AW = 13;
  localparam int L  = 16;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_req, cpu_we, cpu_vs;
  logic [AW-1:0]      cpu_addr;
  logic [L-1:0][31:0] cpu_wdata;
  logic [L-1:0][31:0] cpu_rdata;
  logic               cpu_done, cpu_stall;
  logic               dma_req, dma_we;
  logic [AW-1:0]      dma_addr;
  logic [31:0]        dma_wdata, dma_rdata;
  logic               dma_done;
  logic [AW-1:0]      mem_addr;
  logic               mem_we;
  logic [31:0]        mem_wdata, mem_rdata;

  logic               init_go;
  logic [31:0]        ram [0:(1<<AW)-1];
  logic [31:0]        ref_mem [0:(1<<AW)-1];
  wr_t                wq[$];

  logic [L-1:0][31:0] exp_crd;
  logic [31:0]        exp_drd;
  bit                 last_dma;
  int                 vec = 0;
  int                 miss = 0;

  always #5 clk = ~clk;

  mem_seq_arbiter #(.ADDR_W(AW), .LANES(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_vs(cpu_vs),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'(i);
      ram[16] <= 32'hDEADBEEF;
    end else if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk)
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  // Compare the captured write stream against an expected list
  task automatic chk_writes(input string tag, input wr_t ew[$]);
    bit ok;
    ok = (wq.size() == ew.size());
    if (ok)
      foreach (ew[i]) if (wq[i] !== ew[i]) ok = 1'b0;
    chk({tag, " nwrites"}, 512'(wq.size()), 512'(ew.size()));
    chk({tag, " wstream"}, 512'(ok), 512'(1));
  endtask

  task automatic do_xfer(input bit dma, input bit we, input bit vs,
                         input logic [AW-1:0] a,
                         input logic [L-1:0][31:0] wd,
                         input string tag);
    int n, expc, first, pulses, other;
    bit stall_ok, held, dn, od;
    logic [AW-1:0] ad;
    wr_t ew[$];
    n = (dma || !vs) ? 1 : L;
    expc = we ? n + 1 : n + 2;
    for (int k = 0; k < n; k++) begin
      ad = a + AW'(k);
      if (we) begin
        ew.push_back({ad, wd[L-1-k]});
        ref_mem[ad] = wd[L-1-k];
      end else if (dma) begin
        exp_drd = ref_mem[ad];
      end else if (vs) begin
        exp_crd[L-1-k] = ref_mem[ad];
      end else begin
        exp_crd = '0;
        exp_crd[L-1] = ref_mem[ad];
      end
    end
    last_dma = dma;
    wq.delete();
    if (dma) begin
      dma_req = 1'b1; dma_we = we;
      dma_addr = a; dma_wdata = wd[L-1];
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_vs = vs;
      cpu_addr = a; cpu_wdata = wd;
    end
    #1;
    stall_ok = dma ? 1'b1 : (cpu_stall === 1'b1);
    first = -1; pulses = 0; other = 0; held = 1'b1;
    for (int c = 1; c <= expc + 3; c++) begin
      @(negedge clk);
      dn = dma ? (dma_done === 1'b1) : (cpu_done === 1'b1);
      od = dma ? (cpu_done === 1'b1) : (dma_done === 1'b1);
      if (od) other++;
      if (!dma && held && cpu_stall !== !dn) stall_ok = 1'b0;
      if (!dma && !held && cpu_stall !== 1'b0) stall_ok = 1'b0;
      if (c == 1) begin
        if (dma) begin
          dma_we = ~we; dma_addr = AW'($urandom);
          dma_wdata = $urandom;
        end else begin
          cpu_we = ~we; cpu_vs = ~vs;
          cpu_addr = AW'($urandom);
          for (int j = 0; j < L; j++) cpu_wdata[j] = $urandom;
        end
      end
      if (dn) begin
        pulses++;
        if (first < 0) first = c;
        drop_all();
        held = 1'b0;
      end
    end
    drop_all();
    chk({tag, " done_cycle"}, 512'(first), 512'(expc));
    chk({tag, " done_pulses"}, 512'(pulses), 512'(1));
    chk({tag, " other_done"}, 512'(other), 512'(0));
    chk({tag, " stall"}, 512'(stall_ok), 512'(1));
    chk_writes(tag, ew);
    chk({tag, " cpu_rdata"}, 512'(cpu_rdata), 512'(exp_crd));
    chk({tag, " dma_rdata"}, 512'(dma_rdata), 512'(exp_drd));
    chk({tag, " idle_bus"},
        512'({mem_we, mem_addr, mem_wdata}), 512'(0));
  endtask

  initial begin : main
    logic [L-1:0][31:0] wd;
    wr_t ew[$];
    logic [3:0] order, exp_order;
    int n, cf, df;
    bit g;

    rst = 1'b1; init_go = 1'b1;
    drop_all();
    cpu_we = 0; cpu_vs = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'(i);
    ref_mem[16] = 32'hDEADBEEF;
    exp_crd = '0; exp_drd = '0; last_dma = 1'b1;
    repeat (2) @(negedge clk);
    init_go = 1'b0;
    chk("reset outputs",
        512'({cpu_done, dma_done, cpu_stall, mem_we,
              mem_addr, mem_wdata, dma_rdata}), 512'(0));
    chk("reset cpu_rdata", 512'(cpu_rdata), 512'(0));
    rst = 1'b0;

    // Both requesters held high for four grants
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vs = 1'b0;
    cpu_addr = AW'(16);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'(12'h123);
    exp_order = '0;
    for (int i = 0; i < 4; i++) begin
      g = RR ? !last_dma : 1'b0;
      exp_order[i] = g;
      last_dma = g;
      if (g) exp_drd = ref_mem[12'h123];
      else begin
        exp_crd = '0; exp_crd[L-1] = ref_mem[16];
      end
    end
    order = '0; n = 0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_done === 1'b1) begin order[n] = 1'b0; n++; end
      else if (dma_done === 1'b1) begin order[n] = 1'b1; n++; end
    end
    drop_all();
    repeat (3) @(negedge clk);
    chk("arb grants", 512'(n), 512'(4));
    chk("arb order", 512'(order), 512'(exp_order));
    chk("arb cpu_rdata", 512'(cpu_rdata), 512'(exp_crd));
    chk("arb dma_rdata", 512'(dma_rdata), 512'(exp_drd));

    for (int j = 0; j < L; j++) wd[j] = 32'h100 + 32'(j);
    do_xfer(0, 1, 1, AW'(13'h1FF8), wd, "vst_wrap");
    do_xfer(0, 0, 1, AW'(13'h0040), wd, "vld");
    do_xfer(0, 0, 0, AW'(13'h0010), wd, "sld");
    do_xfer(0, 1, 0, AW'(13'h0020), wd, "sst");
    do_xfer(1, 1, 0, AW'(13'h0030), wd, "dst");
    do_xfer(1, 0, 0, AW'(13'h1FFA), wd, "dld");

    // DMA store raised mid-way through a CPU vector store
    for (int j = 0; j < L; j++) wd[j] = $urandom;
    ew.delete(); wq.delete();
    for (int k = 0; k < L; k++) begin
      ew.push_back({AW'(13'h0200 + k), wd[L-1-k]});
      ref_mem[13'h0200 + k] = wd[L-1-k];
    end
    ew.push_back({AW'(5), 32'h1234});
    ref_mem[5] = 32'h1234;
    last_dma = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vs = 1'b1;
    cpu_addr = AW'(13'h0200); cpu_wdata = wd;
    cf = -1; df = -1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (cpu_done === 1'b1 && cf < 0) begin
        cf = c; cpu_req = 1'b0;
      end
      if (dma_done === 1'b1 && df < 0) begin
        df = c; dma_req = 1'b0;
      end
      if (c == 4) begin
        dma_req = 1'b1; dma_we = 1'b1;
        dma_addr = AW'(5); dma_wdata = 32'h1234;
      end
    end
    drop_all();
    chk("mid cpu_done", 512'(cf), 512'(17));
    chk("mid dma_done", 512'(df), 512'(20));
    chk_writes("mid", ew);

    // Reset during beat 5 of a vector store
    for (int j = 0; j < L; j++) wd[j] = $urandom;
    ew.delete(); wq.delete();
    for (int k = 0; k < 6; k++) begin
      ew.push_back({AW'(13'h0300 + k), wd[L-1-k]});
      ref_mem[13'h0300 + k] = wd[L-1-k];
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vs = 1'b1;
    cpu_addr = AW'(13'h0300); cpu_wdata = wd;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst outputs",
        512'({cpu_done, dma_done, mem_we, mem_addr,
              mem_wdata, dma_rdata}), 512'(0));
    chk("rst cpu_rdata", 512'(cpu_rdata), 512'(0));
    rst = 1'b0; drop_all();
    exp_crd = '0; exp_drd = '0; last_dma = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_done === 1'b1 || mem_we === 1'b1) n++;
    end
    chk("rst quiet", 512'(n), 512'(0));
    chk_writes("rst", ew);

    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < L; j++) wd[j] = $urandom;
      do_xfer(($urandom % 3) == 0, 1'($urandom), 1'($urandom),
              AW'($urandom), wd, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
